// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the D-stage hazard / stall controller:
//   - Tuse / Tnew encodings (TUSE_NONE = 3 means "operand not read")
//   - default multiply / divide busy-cycle counts
//   - reg_hazard(): Tuse/Tnew dependency test of one source operand
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam int MULT_CYCLES_DFLT = 5;
  localparam int DIV_CYCLES_DFLT  = 10;

  typedef enum logic [1:0] {
    TUSE_0    = 2'd0,
    TUSE_1    = 2'd1,
    TUSE_2    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  typedef enum logic [1:0] {
    TNEW_0 = 2'd0,
    TNEW_1 = 2'd1,
    TNEW_2 = 2'd2
  } tnew_e;

  // A source operand must wait when a younger-stage producer writes the same
  // non-zero register and the result arrives later than the operand is needed.
  // TUSE_NONE (3) can never be below a legal Tnew, so it never stalls.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == e_wa) && (tuse < e_tnew);
    hit_m = (src == m_wa) && (tuse < m_tnew);
    return (src != 5'd0) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the decoder-side inputs and pipeline-control outputs of the hazard
// controller.
//   slave  : the controller (reads D/E/M decode info, drives stall/enables)
//   master : the pipeline / stimulus side
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;

  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_is_md;
  logic [4:0] E_wa;
  logic [4:0] M_wa;
  logic [1:0] E_tnew;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       M_REQ;
  logic       stall;
  logic       F_en;
  logic       D_en;
  logic       md_busy;

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_wa, M_wa, E_tnew, M_tnew, E_md_start, E_md_is_div, M_REQ,
    output stall, F_en, D_en, md_busy
  );

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_wa, M_wa, E_tnew, M_tnew, E_md_start, E_md_is_div, M_REQ,
    input  stall, F_en, D_en, md_busy
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Tracks how long the multiply/divide unit stays busy after an issue.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : MDU operation issues this cycle (already flush-qualified)
//   is_div_i   : issuing operation is a divide
//   md_busy_o  : counter non-zero (registered state)
// A start while the counter is running reloads it.
// -----------------------------------------------------------------------------
module md_busy_counter #(
  parameter int MULT_CYCLES = hazard_stall_ctrl_pkg::MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = hazard_stall_ctrl_pkg::DIV_CYCLES_DFLT,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  output logic md_busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load on issue, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      if (is_div_i) begin
        cnt_d = CNT_W'(DIV_CYCLES);
      end else begin
        cnt_d = CNT_W'(MULT_CYCLES);
      end
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Decides per cycle whether the D-stage instruction is held while a bubble is
// inserted into E.
//   clk, rst  : clock, synchronous active-high reset
//   hif       : slave modport; D/E/M decode inputs, M_REQ flush request,
//               stall / F_en / D_en (combinational) and md_busy (registered)
//   stall_cnt : (HAZARD_PERF_EN only) 32-bit count of stalled cycles
// Optional feature macro: HAZARD_PERF_EN
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_stall_ctrl_if.slave    hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic hz_rs_s;
  logic hz_rt_s;
  logic hz_md_s;
  logic raw_stall_s;
  logic stall_s;
  logic md_start_s;
  logic md_busy_s;

  // A flushed E instruction never issues, so it must not start the MDU.
  assign md_start_s = hif.E_md_start && !hif.M_REQ;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (md_start_s),
    .is_div_i  (hif.E_md_is_div),
    .md_busy_o (md_busy_s)
  );

  // Hazard detection; the flush request overrides any stall so the handler PC
  // can be loaded into F/D in the same cycle.
  always_comb begin
    hz_rs_s = reg_hazard(hif.D_rs, hif.D_tuse_rs, hif.E_wa, hif.E_tnew,
                         hif.M_wa, hif.M_tnew);
    hz_rt_s = reg_hazard(hif.D_rt, hif.D_tuse_rt, hif.E_wa, hif.E_tnew,
                         hif.M_wa, hif.M_tnew);
    // An MDU op issuing from E this cycle is busy before the counter shows it.
    hz_md_s = hif.D_is_md && (md_busy_s || hif.E_md_start);
    raw_stall_s = hz_rs_s || hz_rt_s || hz_md_s;
    if (hif.M_REQ) begin
      stall_s = 1'b0;
    end else begin
      stall_s = raw_stall_s;
    end
  end

  assign hif.stall   = stall_s;
  assign hif.F_en    = !stall_s;
  assign hif.D_en    = !stall_s;
  assign hif.md_busy = md_busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Stalled-cycle counter next value; wraps naturally at 2^32.
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stalled-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if hif();
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_ctrl #(
    .MULT_CYCLES (MULT_C),
    .DIV_CYCLES  (DIV_C),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: absolute cycle index and the last cycle in which the MDU
  // is still busy (md_busy(c) = c <= busy_end).
  int          cyc      = 0;
  int          busy_end = -1;
  logic [31:0] perf_ref = 32'd0;

  typedef struct {
    int rs; int rt; int trs; int trt;
    int ewa; int etnew; int mwa; int mtnew;
    int mreq; int exp_stall;
  } vec_t;

  function automatic bit ref_hz(int r, int tuse, int ewa, int etnew, int mwa, int mtnew);
    if (r == 0) return 1'b0;
    return ((r == ewa) && (tuse < etnew)) || ((r == mwa) && (tuse < mtnew));
  endfunction

  function automatic bit ref_stall();
    bit raw;
    raw = ref_hz(int'(hif.D_rs), int'(hif.D_tuse_rs), int'(hif.E_wa), int'(hif.E_tnew),
                 int'(hif.M_wa), int'(hif.M_tnew))
       || ref_hz(int'(hif.D_rt), int'(hif.D_tuse_rt), int'(hif.E_wa), int'(hif.E_tnew),
                 int'(hif.M_wa), int'(hif.M_tnew))
       || (hif.D_is_md && ((cyc <= busy_end) || hif.E_md_start));
    return raw && !hif.M_REQ;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model (and
  // optional fixed expectations, -1 = none), then advance the model at the edge.
  task automatic cycle(input string nm, input int xs, input int xb);
    bit es;
    bit eb;
    @(negedge clk);
    es = ref_stall();
    eb = (cyc <= busy_end);
    check({nm, ".stall"},   32'(hif.stall),   32'(es));
    check({nm, ".F_en"},    32'(hif.F_en),    32'(!es));
    check({nm, ".D_en"},    32'(hif.D_en),    32'(!es));
    check({nm, ".md_busy"}, 32'(hif.md_busy), 32'(eb));
    if (xs >= 0) check({nm, ".stall_fixed"},   32'(hif.stall),   32'(xs));
    if (xb >= 0) check({nm, ".md_busy_fixed"}, 32'(hif.md_busy), 32'(xb));
`ifdef HAZARD_PERF_EN
    check({nm, ".stall_cnt"}, stall_cnt, perf_ref);
`endif
    @(posedge clk);
    if (rst) begin
      if (busy_end > cyc) busy_end = cyc;
      perf_ref = 32'd0;
    end else begin
      if (hif.E_md_start && !hif.M_REQ)
        busy_end = cyc + (hif.E_md_is_div ? DIV_C : MULT_C);
      if (es) perf_ref = perf_ref + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    hif.D_rs = 5'd0;        hif.D_rt = 5'd0;
    hif.D_tuse_rs = 2'd3;   hif.D_tuse_rt = 2'd3;
    hif.D_is_md = 1'b0;
    hif.E_wa = 5'd0;        hif.M_wa = 5'd0;
    hif.E_tnew = 2'd0;      hif.M_tnew = 2'd0;
    hif.E_md_start = 1'b0;  hif.E_md_is_div = 1'b0;
    hif.M_REQ = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8, 0, 1, 3, 8, 2, 0, 0, 0, 1};  // load-use from E
    vecs[1] = '{8, 0, 1, 3, 0, 0, 8, 1, 0, 0};  // producer moved to M, now ready
    vecs[2] = '{0, 0, 3, 0, 0, 2, 0, 0, 0, 0};  // $0 exemption
    vecs[3] = '{5, 0, 0, 3, 0, 0, 5, 1, 0, 1};  // M producer, tuse 0
    vecs[4] = '{0, 7, 3, 0, 7, 0, 0, 0, 0, 0};  // E result already ready
    vecs[5] = '{0, 7, 3, 1, 7, 2, 0, 0, 0, 1};  // rt hazard on E
    vecs[6] = '{9, 0, 3, 3, 9, 2, 9, 1, 0, 0};  // operand not used
    vecs[7] = '{8, 0, 1, 3, 8, 2, 0, 0, 1, 0};  // flush masks hazard
    vecs[8] = '{4, 6, 2, 1, 3, 2, 6, 1, 0, 0};  // rt on M, tuse == tnew
    vecs[9] = '{4, 6, 2, 0, 3, 2, 6, 1, 0, 1};  // rt on M, tuse < tnew

    idle_inputs();
    rst = 1'b1;
    cycle("reset0", -1, 0);
    cycle("reset1", -1, 0);
    rst = 1'b0;
    cycle("post_reset", 0, 0);

    // Table-driven single-cycle hazard vectors.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      hif.D_rs = 5'(vecs[i].rs);        hif.D_rt = 5'(vecs[i].rt);
      hif.D_tuse_rs = 2'(vecs[i].trs);  hif.D_tuse_rt = 2'(vecs[i].trt);
      hif.E_wa = 5'(vecs[i].ewa);       hif.E_tnew = 2'(vecs[i].etnew);
      hif.M_wa = 5'(vecs[i].mwa);       hif.M_tnew = 2'(vecs[i].mtnew);
      hif.M_REQ = vecs[i].mreq[0];
      cycle($sformatf("vec%0d", i), vecs[i].exp_stall, 0);
    end

    // mult followed by a held mflo.
    idle_inputs();
    hif.D_is_md = 1'b1;
    for (int k = 0; k < 8; k++) begin
      hif.E_md_start = (k == 0);
      cycle($sformatf("mult_k%0d", k), (k <= 5) ? 1 : 0, (k >= 1 && k <= 5) ? 1 : 0);
    end

    // div busy window.
    idle_inputs();
    for (int k = 0; k < 12; k++) begin
      hif.E_md_start = (k == 0);
      hif.E_md_is_div = (k == 0);
      cycle($sformatf("div_k%0d", k), 0, (k >= 1 && k <= 10) ? 1 : 0);
    end

    // Flush override: hazard plus MDU start under M_REQ.
    idle_inputs();
    hif.D_rs = 5'd8; hif.D_tuse_rs = 2'd1; hif.E_wa = 5'd8; hif.E_tnew = 2'd2;
    hif.D_is_md = 1'b1; hif.E_md_start = 1'b1; hif.M_REQ = 1'b1;
    cycle("flush", 0, 0);
    idle_inputs();
    cycle("flush_after", 0, 0);

    // Reset in the middle of a mult count.
    hif.E_md_start = 1'b1;
    cycle("mid_start", 0, 0);
    idle_inputs();
    cycle("mid_busy", 0, 1);
    rst = 1'b1;
    cycle("mid_rst", -1, 1);
    rst = 1'b0;
    cycle("mid_cleared", 0, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      hif.D_rs = 5'($urandom_range(0, 3));
      hif.D_rt = 5'($urandom_range(0, 3));
      hif.D_tuse_rs = 2'($urandom_range(0, 3));
      hif.D_tuse_rt = 2'($urandom_range(0, 3));
      hif.D_is_md = 1'($urandom_range(0, 1));
      hif.E_wa = 5'($urandom_range(0, 3));
      hif.M_wa = 5'($urandom_range(0, 3));
      hif.E_tnew = 2'($urandom_range(0, 2));
      hif.M_tnew = 2'($urandom_range(0, 1));
      hif.E_md_start = ($urandom_range(0, 5) == 0);
      hif.E_md_is_div = 1'($urandom_range(0, 1));
      hif.M_REQ = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cycle("rand", -1, -1);
    end

    rst = 1'b0;
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
